// File: rtl/sad_pkg.sv
// Shared constants, FSM state type and lane-slicing helper for the SAD
// candidate engine and its per-lane absolute-difference stage.
package sad_pkg;

  localparam int PIX_W             = 8;
  localparam int LANES             = 4;
  localparam int WORD_W            = LANES * PIX_W;
  localparam int SAD_W             = 16;
  localparam int IDX_W             = 6;
  localparam int LANE_SUM_W        = PIX_W + $clog2(LANES);
  localparam int DEF_WORDS_PER_BLK = 64;
  localparam int DEF_NUM_CAND      = 49;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } sad_state_e;

  // Lane 0 sits in the least significant byte of a packed pixel word.
  function automatic logic [PIX_W-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                  input int lane);
    return PIX_W'(word >> (lane * PIX_W));
  endfunction

endpackage

// File: rtl/sad_cand_engine_if.sv
// Handshake, pixel bus and result signals between the motion-estimation
// controller (master) and the SAD candidate engine (slave).
interface sad_cand_engine_if;
  import sad_pkg::*;

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] cur_data;
  logic [WORD_W-1:0] ref_data;
  logic              sad_valid;
  logic [SAD_W-1:0]  sad_value;
  logic [IDX_W-1:0]  sad_cand;
  logic              done;
  logic [SAD_W-1:0]  best_sad;
  logic [IDX_W-1:0]  best_idx;
  logic              busy;

  modport master (
    output start, in_valid, cur_data, ref_data,
    input  in_ready, sad_valid, sad_value, sad_cand, done, best_sad, best_idx, busy
  );

  modport slave (
    input  start, in_valid, cur_data, ref_data,
    output in_ready, sad_valid, sad_value, sad_cand, done, best_sad, best_idx, busy
  );

endinterface

// File: rtl/sad_absdiff_lane.sv
// Two-stage absolute difference of one pixel pair: a 9-bit signed difference,
// then magnitude by XOR conditional complement plus the sign bit.
module sad_absdiff_lane
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] cur_i,
  input  logic [PIX_W-1:0] ref_i,
  output logic [PIX_W-1:0] absdiff_o
);

  logic [PIX_W:0]   diff_q;
  logic [PIX_W-1:0] abs_q;

  // Stages run every cycle; validity is tracked alongside in the engine.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      abs_q  <= '0;
    end else begin
      diff_q <= {1'b0, cur_i} - {1'b0, ref_i};
      abs_q  <= (diff_q[PIX_W-1:0] ^ {PIX_W{diff_q[PIX_W]}})
              + {{(PIX_W-1){1'b0}}, diff_q[PIX_W]};
    end
  end

  assign absdiff_o = abs_q;

endmodule

// File: rtl/sad_cand_engine.sv
// Streaming SAD engine: accumulates one SAD per candidate block over a search
// window and tracks the lowest-index minimum for the motion-vector stage.
module sad_cand_engine
  import sad_pkg::*;
#(
  parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK,
  parameter int NUM_CAND      = DEF_NUM_CAND
)(
  input logic              clk,
  input logic              rst,
  sad_cand_engine_if.slave bus
);

  localparam int WC_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;

  sad_state_e       state_q;
  logic [WC_W-1:0]  word_cnt_q;
  logic [IDX_W-1:0] cand_cnt_q;

  logic             s1_valid_q, s1_last_q;
  logic [IDX_W-1:0] s1_cand_q;
  logic             s2_valid_q, s2_last_q;
  logic [IDX_W-1:0] s2_cand_q;
  logic [SAD_W-1:0] acc_q, acc_d;

  logic             in_ready_q;
  logic             sad_valid_q;
  logic [SAD_W-1:0] sad_value_q;
  logic [IDX_W-1:0] sad_cand_q;
  logic             done_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             busy_q;

  logic [PIX_W-1:0]      cur_lane [LANES];
  logic [PIX_W-1:0]      ref_lane [LANES];
  logic [PIX_W-1:0]      absdiff  [LANES];
  logic [LANE_SUM_W-1:0] lane_sum;

  logic accept;
  logic last_word;
  logic last_cand;
  logic cand_end;

  assign accept    = in_ready_q & bus.in_valid;
  assign last_word = (word_cnt_q == WC_W'(WORDS_PER_BLK - 1));
  assign last_cand = (cand_cnt_q == IDX_W'(NUM_CAND - 1));
  assign cand_end  = s2_valid_q & s2_last_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign cur_lane[g] = lane_slice(bus.cur_data, g);
    assign ref_lane[g] = lane_slice(bus.ref_data, g);

    sad_absdiff_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .cur_i     (cur_lane[g]),
      .ref_i     (ref_lane[g]),
      .absdiff_o (absdiff[g])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + LANE_SUM_W'(absdiff[l]);
    end
    acc_d = acc_q + SAD_W'(lane_sum);
  end

  // Valid/last/index tags ride beside the lane registers; the accumulator
  // restarts at zero right after a candidate's final word so there is no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_cand_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_cand_q  <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= last_word;
      s1_cand_q  <= cand_cnt_q;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_cand_q  <= s1_cand_q;
      if (s2_valid_q) begin
        acc_q <= s2_last_q ? '0 : acc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      cand_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      sad_valid_q <= 1'b0;
      sad_value_q <= '0;
      sad_cand_q  <= '0;
      done_q      <= 1'b0;
      best_sad_q  <= '0;
      best_idx_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      sad_valid_q <= 1'b0;
      done_q      <= 1'b0;

      // Strict compare keeps the earliest candidate on a tie.
      if (cand_end) begin
        sad_valid_q <= 1'b1;
        sad_value_q <= acc_d;
        sad_cand_q  <= s2_cand_q;
        if (acc_d < best_sad_q) begin
          best_sad_q <= acc_d;
          best_idx_q <= s2_cand_q;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            word_cnt_q <= '0;
            cand_cnt_q <= '0;
            best_sad_q <= '1;
            best_idx_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            if (last_word) begin
              word_cnt_q <= '0;
              if (last_cand) begin
                state_q    <= FLUSH;
                in_ready_q <= 1'b0;
              end else begin
                cand_cnt_q <= cand_cnt_q + 1'b1;
              end
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (sad_valid_q && (sad_cand_q == IDX_W'(NUM_CAND - 1))) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sad_valid = sad_valid_q;
  assign bus.sad_value = sad_value_q;
  assign bus.sad_cand  = sad_cand_q;
  assign bus.done      = done_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_idx  = best_idx_q;
  assign bus.busy      = busy_q;

endmodule
